// File: rtl/word_narrower.sv
// Narrows 32-bit words into a 16-bit beat stream, sending a single beat
// when the upper half is only a sign extension of the lower half.
module word_narrower #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_half,
    output logic             out_compact,
    output logic             out_last,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] compact_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_LO,
        SEND_HI
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      word_q, word_d;
    logic             cmp_q, cmp_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] ccnt_q, ccnt_d;
    logic             in_cmp;

    assign in_cmp = (in_word[31:16] == {16{in_word[15]}});

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cmp_d       = cmp_q;
        wcnt_d      = wcnt_q;
        ccnt_d      = ccnt_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_half    = 16'h0000;
        out_compact = 1'b0;
        out_last    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_word;
                    cmp_d   = in_cmp;
                    state_d = SEND_LO;
                    // Counters stick at all-ones instead of wrapping
                    if (wcnt_q != '1) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                    if (in_cmp && (ccnt_q != '1)) begin
                        ccnt_d = ccnt_q + 1'b1;
                    end
                end
            end
            SEND_LO: begin
                out_valid   = 1'b1;
                out_half    = word_q[15:0];
                out_compact = cmp_q;
                out_last    = cmp_q;
                if (out_ready) begin
                    state_d = cmp_q ? IDLE : SEND_HI;
                end
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_half  = word_q[31:16];
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= 32'h0;
            cmp_q   <= 1'b0;
            wcnt_q  <= '0;
            ccnt_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cmp_q   <= cmp_d;
            wcnt_q  <= wcnt_d;
            ccnt_q  <= ccnt_d;
        end
    end

    assign word_cnt    = wcnt_q;
    assign compact_cnt = ccnt_q;

endmodule
